// File: rtl/mem_unpack_engine_if.sv
// Load/start/status/read-back bundle for mem_unpack_engine.
// The engine connects to the slave modport. The loader or the bench connects to the master modport.
interface mem_unpack_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SRC_AW = 8
);
  logic                     ld_en;
  logic [SRC_AW-1:0]        ld_addr;
  logic [ADDR_W+DATA_W-1:0] ld_data;
  logic                     start;
  logic [SRC_AW-1:0]        base;
  logic [SRC_AW:0]          count;
  logic                     busy;
  logic                     done;
  logic [SRC_AW:0]          wr_count;
  logic [ADDR_W-1:0]        last_addr;
  logic [DATA_W-1:0]        last_data;
  logic [2:0]               state_o;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [DATA_W-1:0]        csum;

  modport master (
    output ld_en, ld_addr, ld_data, start, base, count, rd_addr,
    input  busy, done, wr_count, last_addr, last_data, state_o, rd_data, csum
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, base, count, rd_addr,
    output busy, done, wr_count, last_addr, last_data, state_o, rd_data, csum
  );
endinterface

// File: rtl/mem_unpack_engine.sv
// Walks a window of packed {addr,data} source words and scatters the data fields into a destination RAM.
// Optional running checksum of written data when UNPACK_CSUM_EN is defined.
module mem_unpack_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SRC_AW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_unpack_engine_if.slave   bus
);
  localparam int WORD_W    = ADDR_W + DATA_W;
  localparam int SRC_DEPTH = 2 ** SRC_AW;
  localparam int DST_DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SPLIT = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [WORD_W-1:0] src_mem [SRC_DEPTH];
  logic [DATA_W-1:0] dst_mem [DST_DEPTH];

  logic [2:0]        state;
  logic [SRC_AW-1:0] ptr;
  logic [SRC_AW:0]   rem;
  logic [SRC_AW:0]   wr_count;
  logic [WORD_W-1:0] word_r;
  logic [ADDR_W-1:0] a_r;
  logic [DATA_W-1:0] d_r;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              start_ok;
  logic [SRC_AW:0]   count_clamped;

  assign busy          = (state == S_FETCH) || (state == S_SPLIT) || (state == S_WRITE);
  assign start_ok      = (state == S_IDLE) && bus.start;
  assign count_clamped = (bus.count > (SRC_AW+1)'(SRC_DEPTH)) ? (SRC_AW+1)'(SRC_DEPTH) : bus.count;

  // Loads are dropped while a run is in flight so the window cannot change under the walker.
  always_ff @(posedge clk) begin
    if (bus.ld_en && !busy) src_mem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk) begin
    if (state == S_WRITE) dst_mem[a_r] <= d_r;
  end

  // The read port samples the array before the same-edge write lands, so it returns the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= dst_mem[bus.rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      rem       <= '0;
      wr_count  <= '0;
      word_r    <= '0;
      a_r       <= '0;
      d_r       <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ptr      <= bus.base;
            rem      <= count_clamped;
            wr_count <= '0;
            state    <= (count_clamped == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          word_r <= src_mem[ptr];
          state  <= S_SPLIT;
        end
        S_SPLIT: begin
          a_r   <= word_r[WORD_W-1:DATA_W];
          d_r   <= word_r[DATA_W-1:0];
          state <= S_WRITE;
        end
        S_WRITE: begin
          last_addr <= a_r;
          last_data <= d_r;
          wr_count  <= wr_count + (SRC_AW+1)'(1);
          ptr       <= ptr + SRC_AW'(1);
          rem       <= rem - (SRC_AW+1)'(1);
          state     <= (rem == (SRC_AW+1)'(1)) ? S_DONE : S_FETCH;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UNPACK_CSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    csum <= '0;
    else if (start_ok)          csum <= '0;
    else if (state == S_WRITE)  csum <= csum + d_r;
  end

  assign bus.csum = csum;
`else
  assign bus.csum = '0;
`endif

  assign bus.busy      = busy;
  assign bus.done      = (state == S_DONE);
  assign bus.wr_count  = wr_count;
  assign bus.last_addr = last_addr;
  assign bus.last_data = last_data;
  assign bus.state_o   = state;
  assign bus.rd_data   = rd_data;
endmodule

// File: tb/tb_mem_unpack_engine.sv
// Self-checking bench for mem_unpack_engine: directed scenarios plus random windows checked against an array model.
module tb_mem_unpack_engine;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_unpack_engine_if bus ();

  mem_unpack_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m_src [256];
  logic [7:0]  m_dst [256];
  bit          m_vld [256];
  logic [7:0]  m_last_a;
  logic [7:0]  m_last_d;
  logic [7:0]  m_csum;
  int          m_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_csum();
`ifdef UNPACK_CSUM_EN
    return m_csum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic load(input logic [7:0] a, input logic [15:0] w);
    @(negedge clk);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = w;
    @(negedge clk);
    bus.ld_en = 1'b0;
    m_src[a] = w;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.rd_addr = a;
    @(negedge clk);
    d = bus.rd_data;
  endtask

  // Reference: a window of n entries, clamped to the RAM depth, each scattered in order.
  function automatic int model_run(input logic [7:0] b, input int c);
    int n;
    logic [15:0] w;
    n = (c > 256) ? 256 : c;
    m_wr   = 0;
    m_csum = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = m_src[(int'(b) + k) % 256];
      m_dst[w[15:8]] = w[7:0];
      m_vld[w[15:8]] = 1'b1;
      m_last_a = w[15:8];
      m_last_d = w[7:0];
      m_csum   = m_csum + w[7:0];
      m_wr++;
    end
    return n;
  endfunction

  task automatic verify_dest(input string tag);
    logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      if (m_vld[a]) begin
        rd(8'(a), d);
        check(tag, {24'h0, d}, {24'h0, m_dst[a]});
      end
    end
  endtask

  task automatic run(input logic [7:0] b, input int c, input bit hammer,
                     input bit ld_same, input logic [15:0] ld_w, input string tag);
    int n;
    int busy_cnt;
    int done_at;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = b;
    bus.count = 9'(c);
    if (ld_same) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = b;
      bus.ld_data = ld_w;
      m_src[b]    = ld_w;
    end
    n = model_run(b, c);
    @(posedge clk);
    busy_cnt = 0;
    done_at  = 0;
    pulses   = 0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        pulses++;
        if (done_at == 0) done_at = i;
      end
      if (hammer && bus.busy) begin
        bus.start   = 1'b1;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 8'($urandom);
        bus.ld_data = 16'($urandom);
      end else begin
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
      end
      if (done_at != 0 && i >= done_at + 3) break;
    end
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    check({tag, ".done_cycle"}, done_at, 3 * n + 1);
    check({tag, ".busy_cycles"}, busy_cnt, 3 * n);
    check({tag, ".done_pulses"}, pulses, 1);
    check({tag, ".wr_count"}, {23'h0, bus.wr_count}, m_wr);
    check({tag, ".last_addr"}, {24'h0, bus.last_addr}, {24'h0, m_last_a});
    check({tag, ".last_data"}, {24'h0, bus.last_data}, {24'h0, m_last_d});
    check({tag, ".csum"}, {24'h0, bus.csum}, {24'h0, exp_csum()});
  endtask

  initial begin
    logic [7:0] d;
    total = 0;
    bad   = 0;
    m_last_a = 8'h00;
    m_last_d = 8'h00;
    m_csum   = 8'h00;
    m_wr     = 0;
    for (int a = 0; a < 256; a++) m_vld[a] = 1'b0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.start   = 1'b0;
    bus.base    = '0;
    bus.count   = '0;
    bus.rd_addr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.state",   {29'h0, bus.state_o}, 0);
    check("rst.busy",    {31'h0, bus.busy}, 0);
    check("rst.done",    {31'h0, bus.done}, 0);
    check("rst.wr_cnt",  {23'h0, bus.wr_count}, 0);
    check("rst.last_a",  {24'h0, bus.last_addr}, 0);
    check("rst.last_d",  {24'h0, bus.last_data}, 0);
    check("rst.rd_data", {24'h0, bus.rd_data}, 0);
    check("rst.csum",    {24'h0, bus.csum}, 0);
    rst = 1'b0;

    for (int a = 0; a < 256; a++) load(8'(a), 16'($urandom));

    // Basic four-entry unpack.
    load(8'd0, 16'h1011); load(8'd1, 16'h2022); load(8'd2, 16'h3033); load(8'd3, 16'h4044);
    run(8'd0, 4, 1'b0, 1'b0, 16'h0, "basic");
    rd(8'h10, d); check("basic.rd10", {24'h0, d}, 32'h11);
    rd(8'h20, d); check("basic.rd20", {24'h0, d}, 32'h22);
    rd(8'h30, d); check("basic.rd30", {24'h0, d}, 32'h33);
    rd(8'h40, d); check("basic.rd40", {24'h0, d}, 32'h44);
`ifdef UNPACK_CSUM_EN
    check("basic.csum_abs", {24'h0, bus.csum}, 32'hAA);
`endif

    run(8'd9, 0, 1'b0, 1'b0, 16'h0, "zero");
    verify_dest("zero.dest");

    load(8'd254, 16'h0501); load(8'd255, 16'h0602); load(8'd0, 16'h0703);
    run(8'd254, 3, 1'b0, 1'b0, 16'h0, "wrap");
    rd(8'h05, d); check("wrap.rd5", {24'h0, d}, 32'h01);
    rd(8'h06, d); check("wrap.rd6", {24'h0, d}, 32'h02);
    rd(8'h07, d); check("wrap.rd7", {24'h0, d}, 32'h03);

    load(8'd0, 16'h5511); load(8'd1, 16'h5522);
    run(8'd0, 2, 1'b0, 1'b0, 16'h0, "dup");
    rd(8'h55, d); check("dup.rd55", {24'h0, d}, 32'h22);

    run(8'($urandom), 5, 1'b1, 1'b0, 16'h0, "hammer");

    for (int r = 0; r < 6; r++) begin
      run(8'($urandom), int'($urandom_range(1, 12)), 1'b0, (r == 0), 16'($urandom), "rand");
    end
    run(8'($urandom), 300, 1'b0, 1'b0, 16'h0, "full");
    verify_dest("full.dest");

    // Abort during SPLIT of the second entry.
    load(8'd0, 16'hA000); load(8'd1, 16'hA100); load(8'd2, 16'hA200); load(8'd3, 16'hA300);
    run(8'd0, 4, 1'b0, 1'b0, 16'h0, "pre");
    load(8'd0, 16'hA05A); load(8'd1, 16'hA15B); load(8'd2, 16'hA25C); load(8'd3, 16'hA35D);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 8'd0;
    bus.count = 9'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.state",   {29'h0, bus.state_o}, 0);
    check("abort.busy",    {31'h0, bus.busy}, 0);
    check("abort.done",    {31'h0, bus.done}, 0);
    check("abort.wr_cnt",  {23'h0, bus.wr_count}, 0);
    check("abort.last_a",  {24'h0, bus.last_addr}, 0);
    check("abort.last_d",  {24'h0, bus.last_data}, 0);
    check("abort.rd_data", {24'h0, bus.rd_data}, 0);
    check("abort.csum",    {24'h0, bus.csum}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.no_done", {31'h0, bus.done}, 0);
    m_dst[8'hA0] = 8'h5A;
    verify_dest("abort.dest");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
